// File: rtl/temp_avg_pkg.sv
// Shared types and helpers for the temperature moving-average stage.
package temp_avg_pkg;

    localparam int TEMP_W         = 6;
    localparam int LOG2_N_DEFAULT = 3;
    // Widest running sum over the legal window depths (LOG2_N up to 6).
    localparam int SUM_MAX_W      = TEMP_W + 6;

    typedef logic [TEMP_W-1:0] temp_t;

    // Divide by 2**log2n, rounding halves up.
    function automatic temp_t round_shift(input logic [SUM_MAX_W-1:0] sum, input int log2n);
        logic [SUM_MAX_W:0] t;
        t = {1'b0, sum} + ((SUM_MAX_W+1)'(1) << (log2n - 1));
        return temp_t'(t >> log2n);
    endfunction

endpackage

// File: rtl/temp_sample_ring.sv
// N-entry circular sample buffer; presents the entry about to be overwritten.
module temp_sample_ring
    import temp_avg_pkg::*;
#(
    parameter int LOG2_N = LOG2_N_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [TEMP_W-1:0] wr_data,
    output logic [TEMP_W-1:0] rd_data
);

    localparam int N = 1 << LOG2_N;

    logic [TEMP_W-1:0] mem_q [N];
    logic [LOG2_N-1:0] wr_ptr_q;
    logic [LOG2_N-1:0] wr_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Contents are meaningless until written, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[wr_ptr_q];

endmodule

// File: rtl/temp_window_avg.sv
// Sliding-window rounded average of temperature samples for the display decoder.
module temp_window_avg
    import temp_avg_pkg::*;
#(
    parameter int LOG2_N = LOG2_N_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] sample,
    output logic [TEMP_W-1:0] avg,
    output logic              avg_valid,
    output logic              filled
);

    // Handshake: sample_valid has no ready; every edge with sample_valid high and
    // clear low accepts one sample. avg_valid pulses for one cycle per accepted
    // sample once the window is full and is never held off.

    localparam int N     = 1 << LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam int SUM_W = TEMP_W + LOG2_N;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    temp_t             avg_q, avg_d;
    logic              avg_valid_q, avg_valid_d;
    logic              filled_q, filled_d;
    logic              accept;
    logic              full;
    logic [TEMP_W-1:0] ring_rd;
    logic [TEMP_W-1:0] oldest;

    assign accept = sample_valid & ~clear;
    assign full   = (count_q == CNT_W'(N));

    temp_sample_ring #(.LOG2_N(LOG2_N)) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .wr_en   (accept),
        .wr_data (sample),
        .rd_data (ring_rd)
    );

    // Until the window is full the slot being written never contributed to sum.
    assign oldest = full ? ring_rd : '0;

    always_comb begin
        count_d     = count_q;
        sum_d       = sum_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        if (clear) begin
            count_d = '0;
            sum_d   = '0;
            avg_d   = '0;
        end else if (sample_valid) begin
            sum_d = sum_q + SUM_W'(sample) - SUM_W'(oldest);
            if (!full) begin
                count_d = count_q + 1'b1;
            end
            if (count_d == CNT_W'(N)) begin
                avg_d       = round_shift(SUM_MAX_W'(sum_d), LOG2_N);
                avg_valid_d = 1'b1;
            end
        end
        filled_d = (count_d == CNT_W'(N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            filled_q    <= 1'b0;
        end else begin
            count_q     <= count_d;
            sum_q       <= sum_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            filled_q    <= filled_d;
        end
    end

    assign avg       = avg_q;
    assign avg_valid = avg_valid_q;
    assign filled    = filled_q;

endmodule
